pc_fetch_unit: RTL and testbench



---
 rtl/cpu_pkg.sv | 20 ++
 rtl/pc_fetch_unit_sat_counter.sv | 30 +++
 rtl/pc_fetch_unit.sv | 119 +++++++++++
 tb/tb_pc_fetch_unit.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch-stage state type, datapath widths and the
// sign-extension helper used by the decode, LUT and fetch stages.
package cpu_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      HALTED = 2'd2
   } pc_state_t;

   localparam int PC_WIDTH  = 10;
   localparam int REG_WIDTH = 8;
   localparam int CNT_WIDTH = 16;

   // Widened to 32 bits so each caller truncates to its own address width.
   function automatic logic signed [31:0] sign_extend(input logic [REG_WIDTH-1:0] i_val);
      return 32'($signed(i_val));
   endfunction

endpackage

// File: rtl/pc_fetch_unit_sat_counter.sv
// Saturating up-counter with synchronous clear; sticks at all-ones instead of
// wrapping.
module sat_counter #(
   parameter int width = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic             en,
   output logic [width-1:0] count
);

   logic [width-1:0] r_count;
   logic             w_at_max;

   assign w_at_max = (r_count == '1);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_count <= '0;
      end else if (clear) begin
         r_count <= '0;
      end else if (en && !w_at_max) begin
         r_count <= r_count + width'(1);
      end
   end

   assign count = r_count;

endmodule

// File: rtl/pc_fetch_unit.sv
// Program counter and fetch sequencer: start/run/halt lifecycle, PC-relative
// branching on the ALU decision and a saturating retired-instruction count.
module pc_fetch_unit
   import cpu_pkg::*;
#(
   parameter int pc_width  = PC_WIDTH,
   parameter int reg_width = REG_WIDTH,
   parameter int cnt_width = CNT_WIDTH
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic [pc_width-1:0]  start_addr,
   input  logic                 stall,
   input  logic                 branch_en,
   input  logic                 jump,
   input  logic [reg_width-1:0] offset,
   input  logic                 halt_req,
   output logic [pc_width-1:0]  pc,
   output logic                 fetch_en,
   output logic                 done,
   output logic [cnt_width-1:0] instr_cnt
);

   pc_state_t           r_state;
   pc_state_t           w_next_state;
   logic [pc_width-1:0] r_pc;
   logic [pc_width-1:0] w_next_pc;
   logic [pc_width-1:0] w_offset_ext;
   logic                w_cnt_clr;
   logic                w_cnt_en;

   assign w_offset_ext = pc_width'(sign_extend(REG_WIDTH'(offset)));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = IDLE;
      case (r_state)
         IDLE:    w_next_state = start ? RUN : IDLE;
         RUN: begin
            if (start) begin
               w_next_state = RUN;
            end else if (halt_req) begin
               w_next_state = HALTED;
            end else begin
               w_next_state = RUN;
            end
         end
         HALTED:  w_next_state = start ? RUN : HALTED;
         default: w_next_state = IDLE;
      endcase
   end

   always_comb begin
      fetch_en = (r_state == RUN);
      done     = (r_state == HALTED);
   end

   // One action per RUN cycle: restart > halt > stall > taken branch > step.
   always_comb begin
      w_next_pc = r_pc;
      w_cnt_clr = 1'b0;
      w_cnt_en  = 1'b0;
      case (r_state)
         IDLE, HALTED: begin
            if (start) begin
               w_next_pc = start_addr;
               w_cnt_clr = 1'b1;
            end
         end
         RUN: begin
            if (start) begin
               w_next_pc = start_addr;
               w_cnt_clr = 1'b1;
            end else if (halt_req) begin
               w_cnt_en = 1'b1;
            end else if (!stall) begin
               w_cnt_en = 1'b1;
               if (branch_en && jump) begin
                  w_next_pc = r_pc + w_offset_ext;
               end else begin
                  w_next_pc = r_pc + pc_width'(1);
               end
            end
         end
         default: begin
            w_next_pc = r_pc;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_pc <= '0;
      end else begin
         r_pc <= w_next_pc;
      end
   end

   assign pc = r_pc;

   sat_counter #(
      .width (cnt_width)
   ) u_instr_cnt (
      .clk   (clk),
      .reset (reset),
      .clear (w_cnt_clr),
      .en    (w_cnt_en),
      .count (instr_cnt)
   );

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: directed scenarios plus random stimulus, compared
// every cycle against an abstract lifecycle/PC/count model.
module tb_pc_fetch_unit;

   localparam int M_IDLE   = 0;
   localparam int M_RUN    = 1;
   localparam int M_HALTED = 2;

   logic       clk;
   logic       reset;
   logic       start;
   logic [9:0] start_addr;
   logic       stall;
   logic       branch_en;
   logic       jump;
   logic [7:0] offset;
   logic       halt_req;

   logic [9:0]  pc;
   logic        fetch_en;
   logic        done;
   logic [15:0] instr_cnt;

   logic [9:0]  pc_n;
   logic        fetch_en_n;
   logic        done_n;
   logic [3:0]  instr_cnt_n;

   int n_checks = 0;
   int n_pass   = 0;

   int m_state = M_IDLE;
   int m_pc    = 0;
   int m_cnt   = 0;

   pc_fetch_unit dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .start_addr (start_addr),
      .stall      (stall),
      .branch_en  (branch_en),
      .jump       (jump),
      .offset     (offset),
      .halt_req   (halt_req),
      .pc         (pc),
      .fetch_en   (fetch_en),
      .done       (done),
      .instr_cnt  (instr_cnt)
   );

   // Narrow counter copy so saturation is reached often under random stimulus.
   pc_fetch_unit #(
      .pc_width  (10),
      .reg_width (8),
      .cnt_width (4)
   ) dut_narrow (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .start_addr (start_addr),
      .stall      (stall),
      .branch_en  (branch_en),
      .jump       (jump),
      .offset     (offset),
      .halt_req   (halt_req),
      .pc         (pc_n),
      .fetch_en   (fetch_en_n),
      .done       (done_n),
      .instr_cnt  (instr_cnt_n)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int sat(input int v, input int maxv);
      return (v > maxv) ? maxv : v;
   endfunction

   task automatic model_reset();
      m_state = M_IDLE;
      m_pc    = 0;
      m_cnt   = 0;
   endtask

   task automatic model_retire();
      if (m_cnt < 1000000) m_cnt++;
   endtask

   task automatic model_step();
      int off;
      off = int'($signed(offset));
      if (m_state == M_IDLE || m_state == M_HALTED) begin
         if (start) begin
            m_state = M_RUN;
            m_pc    = int'(start_addr);
            m_cnt   = 0;
         end
      end else begin
         if (start) begin
            m_pc  = int'(start_addr);
            m_cnt = 0;
         end else if (halt_req) begin
            m_state = M_HALTED;
            model_retire();
         end else if (!stall) begin
            if (branch_en && jump) m_pc = (m_pc + off + 1024) % 1024;
            else                   m_pc = (m_pc + 1) % 1024;
            model_retire();
         end
      end
   endtask

   always @(negedge clk) begin
      check("pc",          int'(pc),          m_pc);
      check("fetch_en",    int'(fetch_en),    (m_state == M_RUN) ? 1 : 0);
      check("done",        int'(done),        (m_state == M_HALTED) ? 1 : 0);
      check("instr_cnt",   int'(instr_cnt),   sat(m_cnt, 65535));
      check("instr_cnt_n", int'(instr_cnt_n), sat(m_cnt, 15));
      check("pc_n",        int'(pc_n),        m_pc);
   end

   task automatic cyc(input logic s, input logic [9:0] sa, input logic st,
                      input logic br, input logic jp, input logic [7:0] off,
                      input logic h);
      start      = s;
      start_addr = sa;
      stall      = st;
      branch_en  = br;
      jump       = jp;
      offset     = off;
      halt_req   = h;
      @(posedge clk);
      if (!reset) model_step();
      #1;
      start    = 1'b0;
      halt_req = 1'b0;
   endtask

   task automatic step_plain();
      cyc(1'b0, 10'h000, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
   endtask

   initial begin
      reset      = 1'b1;
      start      = 1'b0;
      start_addr = '0;
      stall      = 1'b0;
      branch_en  = 1'b0;
      jump       = 1'b0;
      offset     = '0;
      halt_req   = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check("rst_pc",       int'(pc),        0);
      check("rst_fetch_en", int'(fetch_en),  0);
      check("rst_done",     int'(done),      0);
      check("rst_cnt",      int'(instr_cnt), 0);
      reset = 1'b0;

      // IDLE ignores everything except start
      cyc(1'b0, 10'h0AA, 1'b0, 1'b1, 1'b1, 8'h05, 1'b1);
      check("idle_pc", int'(pc), 0);

      cyc(1'b1, 10'h010, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
      check("start_pc", int'(pc), 10'h010);
      repeat (3) step_plain();
      check("seq_pc",  int'(pc),        10'h013);
      check("seq_cnt", int'(instr_cnt), 3);
      check("seq_fe",  int'(fetch_en),  1);
      check("seq_dn",  int'(done),      0);

      cyc(1'b1, 10'h020, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
      cyc(1'b0, 10'h000, 1'b0, 1'b1, 1'b1, 8'hFC, 1'b0);
      check("br_taken_pc",  int'(pc),        10'h01C);
      check("br_taken_cnt", int'(instr_cnt), 1);
      cyc(1'b0, 10'h000, 1'b0, 1'b1, 1'b0, 8'hFC, 1'b0);
      check("br_nt_pc",  int'(pc),        10'h01D);
      check("br_nt_cnt", int'(instr_cnt), 2);
      cyc(1'b0, 10'h000, 1'b0, 1'b0, 1'b1, 8'h40, 1'b0);
      check("jump_no_br_pc", int'(pc), 10'h01E);

      cyc(1'b1, 10'h000, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
      cyc(1'b0, 10'h000, 1'b0, 1'b1, 1'b1, 8'hFF, 1'b0);
      check("wrap_down", int'(pc), 10'h3FF);
      step_plain();
      check("wrap_up", int'(pc), 10'h000);

      cyc(1'b1, 10'h005, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
      repeat (2) cyc(1'b0, 10'h000, 1'b1, 1'b1, 1'b1, 8'h10, 1'b0);
      check("stall_pc",  int'(pc),        10'h005);
      check("stall_cnt", int'(instr_cnt), 0);
      cyc(1'b0, 10'h000, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
      check("halt_done", int'(done),      1);
      check("halt_fe",   int'(fetch_en),  0);
      check("halt_cnt",  int'(instr_cnt), 1);
      check("halt_pc",   int'(pc),        10'h005);
      cyc(1'b0, 10'h3AA, 1'b1, 1'b1, 1'b1, 8'h80, 1'b1);
      check("halted_hold_pc", int'(pc), 10'h005);

      cyc(1'b1, 10'h100, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
      check("restart_pc",   int'(pc),        10'h100);
      check("restart_cnt",  int'(instr_cnt), 0);
      check("restart_done", int'(done),      0);
      step_plain();
      #2;
      reset = 1'b1;
      model_reset();
      #1;
      check("async_rst_pc", int'(pc),       0);
      check("async_rst_dn", int'(done),     0);
      check("async_rst_fe", int'(fetch_en), 0);
      @(negedge clk);
      #1;
      reset = 1'b0;

      cyc(1'b1, 10'h200, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
      repeat (20) step_plain();
      check("sat_narrow", int'(instr_cnt_n), 15);
      check("sat_wide",   int'(instr_cnt),   20);

      for (int i = 0; i < 4000; i++) begin
         cyc(($urandom_range(0, 99) < 4),
             10'($urandom),
             ($urandom_range(0, 99) < 20),
             ($urandom_range(0, 99) < 35),
             ($urandom_range(0, 1) == 1),
             8'($urandom),
             ($urandom_range(0, 99) < 3));
         if ($urandom_range(0, 199) == 0) begin
            #2;
            reset = 1'b1;
            model_reset();
            @(negedge clk);
            #1;
            reset = 1'b0;
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
